twiddle_rom_param: RTL and testbench

//  Parametrised twiddle/control generator for one radix-2 SDF FFT stage of delay D.

---
 rtl/twiddle_rom_param_if.sv | 23 ++
 rtl/twiddle_rom_param.sv | 145 ++++++++++++++
 tb/tb_twiddle_rom_param.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/twiddle_rom_param_if.sv
// Stage handshake bundle for the SDF twiddle/control generator:
// sample valid in, twiddle, phase state, output valid and k index out.
interface twiddle_rom_param_if #(
    parameter int TW_W = 24,
    parameter int K_W  = 2
);
    logic            in_valid;
    logic [TW_W-1:0] w_r;
    logic [TW_W-1:0] w_i;
    logic [1:0]      state;
    logic            out_valid;
    logic [K_W-1:0]  k_idx;

    modport master (
        output in_valid,
        input  w_r, w_i, state, out_valid, k_idx
    );

    modport slave (
        input  in_valid,
        output w_r, w_i, state, out_valid, k_idx
    );
endinterface

// File: rtl/twiddle_rom_param.sv
// Twiddle/control generator for one radix-2 SDF FFT stage of delay STAGE_D.
// Optional macro TWIDDLE_OUT_REG_EN adds one output register stage.
module twiddle_rom_param #(
    parameter int STAGE_D = 4,
    parameter int TW_W    = 24,
    parameter int FRAC    = 8
) (
    input  logic clk,
    input  logic rst_n,
    twiddle_rom_param_if.slave bus
);
    localparam int  KW = (STAGE_D > 1) ? $clog2(STAGE_D) : 1;
    localparam int  FW = $clog2(STAGE_D + 1);
    localparam int  PW = $clog2(2 * STAGE_D);
    localparam int  TS = 1 << KW;
    localparam real PI = 3.14159265358979323846;

    localparam logic [FW-1:0]   D_F    = FW'(STAGE_D);
    localparam logic [PW-1:0]   D_P    = PW'(STAGE_D);
    localparam logic [PW-1:0]   P_LAST = PW'(2 * STAGE_D - 1);
    localparam logic [TW_W-1:0] ONE    = TW_W'(1) << FRAC;

    // Elaboration-time twiddle value, rounded half away from zero.
    function automatic logic [TW_W-1:0] tw_val(input int k, input bit im);
        real    a;
        real    v;
        longint n;
        a = 2.0 * PI * real'(k) / (2.0 * real'(STAGE_D));
        v = im ? -$sin(a) : $cos(a);
        v = v * (2.0 ** FRAC);
        if (v >= 0.0) n = longint'($floor(v + 0.5));
        else          n = -longint'($floor(-v + 0.5));
        return n[TW_W-1:0];
    endfunction

    logic [TW_W-1:0] w_tbl_r [TS];
    logic [TW_W-1:0] w_tbl_i [TS];

    for (genvar g = 0; g < TS; g++) begin : g_tbl
        localparam logic [TW_W-1:0] C_R = tw_val(g, 1'b0);
        localparam logic [TW_W-1:0] C_I = tw_val(g, 1'b1);
        assign w_tbl_r[g] = C_R;
        assign w_tbl_i[g] = C_I;
    end

    logic [FW-1:0] r_fill;
    logic [PW-1:0] r_phase;
    logic [FW-1:0] r_drain;

    logic          w_full;
    logic          w_drain;
    logic          w_active;
    logic [PW-1:0] w_phase_nx;

    assign w_full     = (r_fill == D_F);
    assign w_drain    = !bus.in_valid && w_full && (r_drain != '0);
    assign w_active   = bus.in_valid || w_drain;
    assign w_phase_nx = (r_phase == P_LAST) ? '0 : r_phase + PW'(1);

    // Fill counter, phase and drain bookkeeping; idle cycles hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill  <= '0;
            r_phase <= '0;
            r_drain <= '0;
        end else if (bus.in_valid) begin
            r_drain <= D_F;
            if (!w_full) r_fill  <= r_fill + FW'(1);
            else         r_phase <= w_phase_nx;
        end else if (w_drain) begin
            if (r_drain == FW'(1)) begin
                r_fill  <= '0;
                r_phase <= '0;
                r_drain <= '0;
            end else begin
                r_phase <= w_phase_nx;
                r_drain <= r_drain - FW'(1);
            end
        end
    end

    logic [1:0]      w_state;
    logic [KW-1:0]   w_k;
    logic [TW_W-1:0] w_wr;
    logic [TW_W-1:0] w_wi;
    logic            w_ov;

    // Phase decode: FILL / PASS emit unity, BFLY looks up W_2D^k.
    always_comb begin
        w_state = 2'd0;
        w_k     = '0;
        w_wr    = ONE;
        w_wi    = '0;
        if (w_full) begin
            if (r_phase < D_P) begin
                w_state = 2'd1;
            end else begin
                w_state = 2'd2;
                w_k     = KW'(r_phase - D_P);
                w_wr    = w_tbl_r[w_k];
                w_wi    = w_tbl_i[w_k];
            end
        end
    end

    assign w_ov = w_active && w_full;

`ifdef TWIDDLE_OUT_REG_EN
    logic [1:0]      r_o_state;
    logic [KW-1:0]   r_o_k;
    logic [TW_W-1:0] r_o_wr;
    logic [TW_W-1:0] r_o_wi;
    logic            r_o_ov;

    // One-cycle output register; resets to the idle/unity outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_state <= 2'd0;
            r_o_k     <= '0;
            r_o_wr    <= ONE;
            r_o_wi    <= '0;
            r_o_ov    <= 1'b0;
        end else begin
            r_o_state <= w_state;
            r_o_k     <= w_k;
            r_o_wr    <= w_wr;
            r_o_wi    <= w_wi;
            r_o_ov    <= w_ov;
        end
    end

    assign bus.state     = r_o_state;
    assign bus.k_idx     = r_o_k;
    assign bus.w_r       = r_o_wr;
    assign bus.w_i       = r_o_wi;
    assign bus.out_valid = r_o_ov;
`else
    assign bus.state     = w_state;
    assign bus.k_idx     = w_k;
    assign bus.w_r       = w_wr;
    assign bus.w_i       = w_wi;
    assign bus.out_valid = w_ov;
`endif

endmodule

// File: tb/tb_twiddle_rom_param.sv
// Directed bench for twiddle_rom_param: D=4/FRAC=8, D=16/FRAC=14, D=1.
// Expected values are hand-computed; output-register build shifts them one cycle.
module tb_twiddle_rom_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef TWIDDLE_OUT_REG_EN
    localparam bit LAT = 1'b1;
`else
    localparam bit LAT = 1'b0;
`endif

    twiddle_rom_param_if #(.TW_W(24), .K_W(2)) if4 ();
    twiddle_rom_param_if #(.TW_W(24), .K_W(4)) if16 ();
    twiddle_rom_param_if #(.TW_W(24), .K_W(1)) if1 ();

    twiddle_rom_param #(.STAGE_D(4), .TW_W(24), .FRAC(8))
        u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    twiddle_rom_param #(.STAGE_D(16), .TW_W(24), .FRAC(14))
        u_d16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    twiddle_rom_param #(.STAGE_D(1), .TW_W(24), .FRAC(8))
        u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct packed {
        logic [1:0]         st;
        logic signed [23:0] wr;
        logic signed [23:0] wi;
        logic               ov;
        logic [3:0]         k;
        logic               cw;
    } exp_t;

    int errs = 0;
    int checks = 0;
    exp_t p4, p16, p1;

    function automatic exp_t mk(logic [1:0] st, logic [23:0] wr,
                                logic [23:0] wi, logic ov,
                                logic [3:0] k, logic cw);
        exp_t x;
        x.st = st; x.wr = wr; x.wi = wi;
        x.ov = ov; x.k = k; x.cw = cw;
        return x;
    endfunction

    function automatic exp_t E(int st, int wr, int wi, int ov, int k);
        return mk(2'(st), 24'(wr), 24'(wi), 1'(ov), 4'(k), 1'b1);
    endfunction

    function automatic exp_t EN(int st, int ov, int k);
        return mk(2'(st), 24'd0, 24'd0, 1'(ov), 4'(k), 1'b0);
    endfunction

    function automatic exp_t obs4();
        return mk(if4.state, if4.w_r, if4.w_i, if4.out_valid, 4'(if4.k_idx), 1'b1);
    endfunction
    function automatic exp_t obs16();
        return mk(if16.state, if16.w_r, if16.w_i, if16.out_valid, if16.k_idx, 1'b1);
    endfunction
    function automatic exp_t obs1();
        return mk(if1.state, if1.w_r, if1.w_i, if1.out_valid, 4'(if1.k_idx), 1'b1);
    endfunction

    task automatic chk(string tag, exp_t o, exp_t x);
        checks++;
        assert (o.st === x.st && o.ov === x.ov && o.k === x.k &&
                (!x.cw || (o.wr === x.wr && o.wi === x.wi)))
        else begin
            errs++;
            $error("FAIL %s: got st=%0d ov=%0d k=%0d w=(%0d,%0d) want st=%0d ov=%0d k=%0d w=(%0d,%0d)",
                   tag, o.st, o.ov, o.k, o.wr, o.wi,
                   x.st, x.ov, x.k, x.wr, x.wi);
        end
    endtask

    task automatic s4(bit iv, exp_t x, string tag);
        @(posedge clk);
        #1 if4.in_valid = iv;
        @(negedge clk);
        chk(tag, obs4(), LAT ? p4 : x);
        p4 = x;
    endtask

    task automatic s16(bit iv, exp_t x, string tag);
        @(posedge clk);
        #1 if16.in_valid = iv;
        @(negedge clk);
        chk(tag, obs16(), LAT ? p16 : x);
        p16 = x;
    endtask

    task automatic s1(bit iv, exp_t x, string tag);
        @(posedge clk);
        #1 if1.in_valid = iv;
        @(negedge clk);
        chk(tag, obs1(), LAT ? p1 : x);
        p1 = x;
    endtask

    int tr4 [4] = '{256, 181, 0, -181};
    int ti4 [4] = '{0, -181, -256, -181};

    initial begin
        exp_t rv, rv16;
        rv   = E(0, 256, 0, 0, 0);
        rv16 = E(0, 16384, 0, 0, 0);
        if4.in_valid = 1'b0;
        if16.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        p4 = rv; p16 = rv16; p1 = rv;

        #2;
        chk("rst_d4", obs4(), rv);
        chk("rst_d16", obs16(), rv16);
        chk("rst_d1", obs1(), rv);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: fill, pass, butterfly
        for (int i = 0; i < 4; i++) s4(1, E(0, 256, 0, 0, 0), $sformatf("t1_fill%0d", i));
        for (int i = 0; i < 4; i++) s4(1, E(1, 256, 0, 1, 0), $sformatf("t1_pass%0d", i));
        for (int i = 0; i < 4; i++) s4(1, E(2, tr4[i], ti4[i], 1, i), $sformatf("t1_bfly%0d", i));

        // Test 2: drain then refill
        for (int i = 0; i < 4; i++) s4(1, E(1, 256, 0, 1, 0), $sformatf("t2_pass%0d", i));
        for (int i = 0; i < 4; i++) s4(0, E(2, tr4[i], ti4[i], 1, i), $sformatf("t2_drain%0d", i));
        for (int i = 0; i < 2; i++) s4(0, E(0, 256, 0, 0, 0), $sformatf("t2_idle%0d", i));
        for (int i = 0; i < 4; i++) s4(1, E(0, 256, 0, 0, 0), $sformatf("t2_refill%0d", i));
        for (int i = 0; i < 4; i++) s4(1, E(1, 256, 0, 1, 0), $sformatf("t2_pass_b%0d", i));

        // Test 3: in_valid returns mid-drain
        s4(0, E(2, tr4[0], ti4[0], 1, 0), "t3_drain0");
        s4(0, E(2, tr4[1], ti4[1], 1, 1), "t3_drain1");
        s4(1, E(2, tr4[2], ti4[2], 1, 2), "t3_resume2");
        s4(1, E(2, tr4[3], ti4[3], 1, 3), "t3_resume3");
        s4(1, E(1, 256, 0, 1, 0), "t3_pass0");
        s4(1, E(1, 256, 0, 1, 0), "t3_pass1");

        // Test 4: async reset in BFLY k=2, then partial fill stalls
        s4(1, E(1, 256, 0, 1, 0), "t4_pass2");
        s4(1, E(1, 256, 0, 1, 0), "t4_pass3");
        s4(1, E(2, tr4[0], ti4[0], 1, 0), "t4_bfly0");
        s4(1, E(2, tr4[1], ti4[1], 1, 1), "t4_bfly1");
        s4(1, E(2, tr4[2], ti4[2], 1, 2), "t4_bfly2");
        #1 rst_n = 1'b0;
        #1 chk("t4_rst_async", obs4(), rv);
        p4 = rv;
        if4.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) s4(1, E(0, 256, 0, 0, 0), $sformatf("t4_part%0d", i));
        for (int i = 0; i < 5; i++) s4(0, E(0, 256, 0, 0, 0), $sformatf("t4_stall%0d", i));
        s4(1, E(0, 256, 0, 0, 0), "t4_fill_last");
        s4(1, E(1, 256, 0, 1, 0), "t4_pass_after");
        s4(0, E(1, 256, 0, 1, 0), "t4_drain_pass");

        // Test 5a: D=16, FRAC=14 full period
        for (int i = 0; i < 16; i++) s16(1, E(0, 16384, 0, 0, 0), $sformatf("t5_fill%0d", i));
        for (int i = 0; i < 16; i++) s16(1, E(1, 16384, 0, 1, 0), $sformatf("t5_pass%0d", i));
        for (int i = 0; i < 16; i++) begin
            exp_t x;
            unique case (i)
                0:       x = E(2, 16384, 0, 1, 0);
                4:       x = E(2, 11585, -11585, 1, 4);
                8:       x = E(2, 0, -16384, 1, 8);
                12:      x = E(2, -11585, -11585, 1, 12);
                default: x = EN(2, 1, i);
            endcase
            s16(1, x, $sformatf("t5_bfly%0d", i));
        end
        s16(1, E(1, 16384, 0, 1, 0), "t5_wrap");
        if16.in_valid = 1'b0;

        // Test 5b: D=1 alternates PASS/BFLY with unity twiddle
        s1(1, E(0, 256, 0, 0, 0), "t5_d1_fill");
        for (int i = 0; i < 3; i++) begin
            s1(1, E(1, 256, 0, 1, 0), $sformatf("t5_d1_pass%0d", i));
            s1(1, E(2, 256, 0, 1, 0), $sformatf("t5_d1_bfly%0d", i));
        end
        s1(0, E(1, 256, 0, 1, 0), "t5_d1_drain");
        s1(0, E(0, 256, 0, 0, 0), "t5_d1_idle");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
